// File: rtl/jpeg_cone_pkg.sv
// Shared constants and helpers for the pipelined JPEG majority/parity cone.
// Holds the MISR constants, the clog2 helper and a reference cone function.
package jpeg_cone_pkg;

   typedef logic [31:0] sig_t;

   localparam sig_t MISR_POLY = 32'h04C1_1DB7;
   localparam sig_t MISR_SEED = 32'hFFFF_FFFF;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   function automatic int unsigned popcount(input logic [63:0] v);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < 64; i++) n += int'(v[i]);
      return n;
   endfunction

   // Operands are LSB-aligned; only the low n bits take part.
   function automatic logic cone_res(input logic [63:0] a, input logic [63:0] b,
                                     input int unsigned n);
      logic [63:0] mask;
      logic        y;
      logic        z;
      for (int unsigned i = 0; i < 64; i++) mask[i] = (i < n);
      y = popcount(a & ~b & mask) > (n / 2);
      z = ^(b & mask);
      return ~(y ^ z);
   endfunction

   function automatic sig_t misr_step(input sig_t s, input sig_t d);
      return {s[30:0], 1'b0} ^ (s[31] ? MISR_POLY : '0) ^ d;
   endfunction

endpackage

// File: rtl/jpeg_cone_fifo.sv
// Output skid FIFO for jpeg_cone_pipe: power-of-2 depth, wrapping pointers,
// saturating level; dout reads as zero while empty.
module jpeg_cone_fifo
   import jpeg_cone_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic [WIDTH-1:0]          din,
   output logic [WIDTH-1:0]          dout,
   output logic                      full,
   output logic                      empty,
   output logic [clog2(DEPTH):0]     level
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/jpeg_cone_pipe.sv
// Elastic pipelined majority/parity cone over NCH channels with output skid FIFO.
// Optional MISR on the output stream is enabled by defining JPEG_CONE_MISR_EN.
module jpeg_cone_pipe
   import jpeg_cone_pkg::*;
#(
   parameter int unsigned N_IN       = 16,
   parameter int unsigned NCH        = 4,
   parameter int unsigned PIPE_STG   = 2,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NCH*N_IN-1:0]           in_a,
   input  logic [NCH*N_IN-1:0]           in_b,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NCH-1:0]                out_res,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [31:0]                   sig_out
);

   localparam int unsigned CW    = clog2(N_IN + 1);
   localparam int unsigned CHUNK = (N_IN + PIPE_STG - 1) / PIPE_STG;
   localparam int unsigned HALF  = N_IN / 2;

   // Stage 0 captures x = a & ~b and z = ^b; stages 1..PIPE_STG each add one chunk.
   logic [PIPE_STG:0]     v;
   logic [PIPE_STG:0]     load;
   logic [NCH*N_IN-1:0]   x_q     [PIPE_STG+1];
   logic [NCH*CW-1:0]     sum_q   [PIPE_STG+1];
   logic [NCH*CW-1:0]     sum_nxt [PIPE_STG+1];
   logic [NCH-1:0]        z_q     [PIPE_STG+1];
   logic [NCH-1:0]        res;
   logic                  push;
   logic                  pop;
   logic                  fifo_full;
   logic                  fifo_empty;

   assign pop       = out_valid & out_ready;
   assign push      = v[PIPE_STG] & (~fifo_full | pop);
   assign out_valid = ~fifo_empty;
   assign in_ready  = load[0] & ~rst;

   // Stage s loads when any stage from s down to the last is empty, or the last pushes.
   always_comb begin
      load = '0;
      for (int unsigned s = 0; s <= PIPE_STG; s++) begin
         load[s] = push;
         for (int unsigned k = s; k <= PIPE_STG; k++)
            if (!v[k]) load[s] = 1'b1;
      end
   end

   always_comb begin
      logic [CW-1:0] acc;
      for (int unsigned s = 0; s <= PIPE_STG; s++) sum_nxt[s] = '0;
      for (int unsigned s = 1; s <= PIPE_STG; s++) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            acc = sum_q[s-1][c*CW +: CW];
            for (int unsigned i = 0; i < N_IN; i++)
               if (i / CHUNK == s - 1) acc = acc + CW'(x_q[s-1][c*N_IN + i]);
            sum_nxt[s][c*CW +: CW] = acc;
         end
      end
   end

   always_comb begin
      res = '0;
      for (int unsigned c = 0; c < NCH; c++)
         res[c] = ~((sum_q[PIPE_STG][c*CW +: CW] > CW'(HALF)) ^ z_q[PIPE_STG][c]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v <= '0;
      end else begin
         if (load[0]) v[0] <= in_valid;
         for (int unsigned s = 1; s <= PIPE_STG; s++)
            if (load[s]) v[s] <= v[s-1];
      end
   end

   always_ff @(posedge clk) begin
      if (load[0] && in_valid) begin
         x_q[0]   <= in_a & ~in_b;
         sum_q[0] <= sum_nxt[0];
         for (int unsigned c = 0; c < NCH; c++)
            z_q[0][c] <= ^in_b[c*N_IN +: N_IN];
      end
      for (int unsigned s = 1; s <= PIPE_STG; s++) begin
         if (load[s]) begin
            x_q[s]   <= x_q[s-1];
            sum_q[s] <= sum_nxt[s];
            z_q[s]   <= z_q[s-1];
         end
      end
   end

   jpeg_cone_fifo #(
      .WIDTH (NCH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (res),
      .dout  (out_res),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

`ifdef JPEG_CONE_MISR_EN
   sig_t misr_q;

   always_ff @(posedge clk) begin
      if (rst)      misr_q <= MISR_SEED;
      else if (pop) misr_q <= misr_step(misr_q, 32'(out_res));
   end

   assign sig_out = misr_q;
`else
   assign sig_out = '0;
`endif

endmodule
